led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Pattern controller that sequences the LED shift datapath on the board top level. It generates the step tick from a switch-selected prescaler and runs a mode-selected pattern state machine (rotate left, rotate right, bounce, flash) with start/stop/hold control. It drives the LED vector plus the blue/green colour split by direction. It replaces the free-running count/shift pair with a controllable sequencer.

## Interface
- NB_LEDS, 4, LED vector width (≥2)
- NB_COUNTER, 16, prescaler width (≥8)
- clock  in  1  system clock
- i_reset  in  1  reset; one clock; reset is asynchronous and active-low
- i_start  in  1  start/restart request, sampled each cycle
- i_stop  in  1  stop request, sampled each cycle
- i_hold  in  1  level; freeze pattern and prescaler while high
- i_mode  in  2  pattern mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FLASH
- i_speed  in  2  step rate select, live (not latched)
- o_led  out  NB_LEDS  current pattern
- o_led_b  out  NB_LEDS  o_led when o_dir=0, else 0
- o_led_g  out  NB_LEDS  o_led when o_dir=1, else 0
- o_dir  out  1  0 = left, 1 = right
- o_tick  out  1  one-cycle pulse coincident with each new o_led step
- o_busy  out  1  high in RUN or HOLD

## Operation
- States: IDLE, RUN, HOLD. Reset → IDLE.
- Request priority each cycle: i_stop > i_start > i_hold.
- Any state + i_stop → IDLE: o_led=0, prescaler=0, o_dir=0.
- Any state + i_start (no stop) → RUN with load:
  - latch i_mode; prescaler=0.
  - ROT_L/BOUNCE: o_led=1 (LSB), o_dir=0.
  - ROT_R: o_led=MSB one-hot, o_dir=1.
  - FLASH: o_led=all ones, o_dir=0.
- RUN + i_hold → HOLD. HOLD + !i_hold → RUN. In HOLD, prescaler and pattern are frozen.
- Prescaler limit: LIMIT(s) = 2^(NB_COUNTER−2·(3−s)) − 1. For NB_COUNTER=16: 1023, 4095, 16383, 65535.
- In RUN, step condition is cnt ≥ LIMIT(i_speed). The ≥ covers a mid-count speed decrease: the step fires on the next cycle.
  - On step: cnt←0 and the pattern updates.
  - Otherwise: cnt←cnt+1.
- Pattern update per step:
  - ROT_L: rotate left, MSB wraps to LSB.
  - ROT_R: rotate right, LSB wraps to MSB.
  - BOUNCE: if o_dir=0 and MSB set → o_dir←1, shift right. If o_dir=1 and LSB set → o_dir←0, shift left. Otherwise shift in o_dir. NB_LEDS=4 sequence: 0001,0010,0100,1000,0100,0010,0001,0010… (period 2·NB_LEDS−2).
  - FLASH: invert o_led.
- i_mode changes while running are ignored until the next start.

## Timing
- All outputs registered. o_led_b/o_led_g are combinational decodes of registered o_led/o_dir.
- Reset values: o_led=0, o_dir=0, o_tick=0, o_busy=0, state IDLE, cnt=0, latched mode=ROT_L.
- Start sampled at edge N: load pattern visible and o_busy=1 after edge N. o_tick is not pulsed for the load.
- First step fires at edge N+LIMIT+1 (cnt counts 0..LIMIT). o_tick is high for the cycle after that edge, together with the new o_led.
- Steady step period = LIMIT+1 cycles.
- Stop at edge N: o_led=0 and o_busy=0 after edge N. A step coinciding with stop is discarded; o_tick stays 0.
- Hold asserted at the same edge as a step condition: hold wins, no step, cnt frozen. Step resumes the edge after release.
- Asynchronous reset mid-run clears all state immediately. First start after reset release behaves as above.

## Structure
- Shared header led_seq_defs.vh: mode encodings (MODE_ROT_L…MODE_FLASH), state encodings, LIMIT computation as a constant function/macro.
- One sub-module led_seq_prescaler: cnt register, clear/enable inputs, speed select, step output.
- The FSM and pattern register live in led_seq_ctrl.

## Test plan
Benches use NB_LEDS=4, NB_COUNTER=8 (LIMIT: s0=3, s1=15, s2=63, s3=255).
- Reset, then start mode ROT_L, speed 0 → o_led 0001 then 0010, 0100, 1000, 0001 at 4-cycle spacing; o_tick single-cycle with each; o_led_b=o_led, o_led_g=0.
- Mode BOUNCE, speed 0, 12 steps → 0010,0100,1000,0100,0010,0001,0010…; o_dir flips on leaving 1000 and 0001; colour outputs follow o_dir.
- Mode ROT_R speed 1, switch i_speed to 0 when cnt=10 → step on the next cycle, then 4-cycle period; o_led 1000→0100→0010.
- Mode FLASH, assert i_hold 2 cycles before a step for 20 cycles → o_led frozen at 1111, no o_tick; first step comes LIMIT−cnt+1 cycles after release → 0000.
- Stop and start asserted together mid-run → IDLE, o_led=0, o_busy=0. Start alone while RUN in ROT_L at 0100 → reload to 0001, cnt=0.
- i_reset low mid-run for one cycle, asynchronous to the clock edge → outputs zero immediately; no activity until the next i_start.

Source files
------------

// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED pattern sequencer: mode/state encodings and
// the prescaler limit formula.
package led_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FLASH  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Each speed step scales the period by 4x; the fastest rate uses nb-6 bits.
   function automatic int unsigned seq_limit(input int unsigned nb, input int unsigned s);
      return (32'd1 << (nb - 2 * (3 - s))) - 32'd1;
   endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: counts 0..LIMIT(speed) and flags a step on the last count.
module led_seq_prescaler
   import led_seq_ctrl_pkg::*;
#(
   parameter int NB_COUNTER = 16
) (
   input  logic       clock,
   input  logic       i_reset,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic [1:0] i_speed,
   output logic       o_step
);

   logic [NB_COUNTER-1:0]      r_cnt;
   logic [3:0][NB_COUNTER-1:0] w_limits;
   logic [NB_COUNTER-1:0]      w_limit;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lim
      assign w_limits[gi] = NB_COUNTER'(seq_limit(NB_COUNTER, gi));
   end

   assign w_limit = w_limits[i_speed];
   // >= so a live speed decrease past the current count steps immediately
   assign o_step  = i_en && (r_cnt >= w_limit);

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset)   r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= o_step ? '0 : r_cnt + 1'b1;
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: start/stop/hold FSM, latched pattern mode, and a
// registered pattern/direction driven by the prescaler step.
module led_seq_ctrl
   import led_seq_ctrl_pkg::*;
#(
   parameter int NB_LEDS    = 4,
   parameter int NB_COUNTER = 16
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_hold,
   input  logic [1:0]         i_mode,
   input  logic [1:0]         i_speed,
   output logic [NB_LEDS-1:0] o_led,
   output logic [NB_LEDS-1:0] o_led_b,
   output logic [NB_LEDS-1:0] o_led_g,
   output logic               o_dir,
   output logic               o_tick,
   output logic               o_busy
);

   state_e             r_state, w_state;
   mode_e              r_mode,  w_mode;
   logic [NB_LEDS-1:0] r_led,   w_led;
   logic               r_dir,   w_dir;
   logic               r_tick,  w_tick;
   logic               w_step, w_clr, w_en;

   // Stop/start override any step; hold in the same cycle also blocks counting.
   assign w_clr = i_stop | i_start;
   assign w_en  = (r_state == ST_RUN) && !i_hold && !w_clr;

   led_seq_prescaler #(.NB_COUNTER(NB_COUNTER)) u_presc (
      .clock   (clock),
      .i_reset (i_reset),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_speed (i_speed),
      .o_step  (w_step)
   );

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_ROT_L;
         r_led   <= '0;
         r_dir   <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_mode  <= w_mode;
         r_led   <= w_led;
         r_dir   <= w_dir;
         r_tick  <= w_tick;
      end
   end

   always_comb begin
      w_state = r_state;
      w_mode  = r_mode;
      w_led   = r_led;
      w_dir   = r_dir;
      w_tick  = 1'b0;
      if (i_stop) begin
         w_state = ST_IDLE;
         w_led   = '0;
         w_dir   = 1'b0;
      end else if (i_start) begin
         w_state = ST_RUN;
         w_mode  = mode_e'(i_mode);
         w_dir   = 1'b0;
         case (mode_e'(i_mode))
            MODE_ROT_R: begin
               w_led = {1'b1, {(NB_LEDS-1){1'b0}}};
               w_dir = 1'b1;
            end
            MODE_FLASH: w_led = '1;
            default:    w_led = NB_LEDS'(1);
         endcase
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_hold) begin
                  w_state = ST_HOLD;
               end else if (w_step) begin
                  w_tick = 1'b1;
                  case (r_mode)
                     MODE_ROT_L: w_led = {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]};
                     MODE_ROT_R: w_led = {r_led[0], r_led[NB_LEDS-1:1]};
                     MODE_FLASH: w_led = ~r_led;
                     default: begin
                        // Direction flips when leaving an end LED
                        if (!r_dir && r_led[NB_LEDS-1]) begin
                           w_dir = 1'b1;
                           w_led = r_led >> 1;
                        end else if (r_dir && r_led[0]) begin
                           w_dir = 1'b0;
                           w_led = r_led << 1;
                        end else begin
                           w_led = r_dir ? (r_led >> 1) : (r_led << 1);
                        end
                     end
                  endcase
               end
            end
            ST_HOLD: if (!i_hold) w_state = ST_RUN;
            default: ;
         endcase
      end
   end

   assign o_led   = r_led;
   assign o_dir   = r_dir;
   assign o_tick  = r_tick;
   assign o_busy  = (r_state != ST_IDLE);
   assign o_led_b = r_dir ? '0 : r_led;
   assign o_led_g = r_dir ? r_led : '0;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios then random traffic, every cycle
// compared against a step-index based reference model.
module tb_led_seq_ctrl;

   logic       clock = 1'b0;
   logic       i_reset, i_start, i_stop, i_hold;
   logic [1:0] i_mode, i_speed;
   logic [3:0] o_led, o_led_b, o_led_g;
   logic       o_dir, o_tick, o_busy;

   int n_cmp = 0;
   int n_err = 0;

   led_seq_ctrl #(.NB_LEDS(4), .NB_COUNTER(8)) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_start (i_start),
      .i_stop  (i_stop),
      .i_hold  (i_hold),
      .i_mode  (i_mode),
      .i_speed (i_speed),
      .o_led   (o_led),
      .o_led_b (o_led_b),
      .o_led_g (o_led_g),
      .o_dir   (o_dir),
      .o_tick  (o_tick),
      .o_busy  (o_busy)
   );

   always #5 clock = ~clock;

   // Reference model: run/hold flags, latched mode, step index and cycle count.
   int LIM[4] = '{3, 15, 63, 255};
   bit m_busy, m_held, m_tick;
   int m_mode, m_k, m_cnt;

   function automatic logic [3:0] pat(int md, int k);
      int p, pos;
      case (md)
         0: return 4'b0001 << (k % 4);
         1: return 4'b1000 >> (k % 4);
         2: begin
            p   = k % 6;
            pos = (p < 4) ? p : 6 - p;
            return 4'b0001 << pos;
         end
         default: return (k % 2 == 0) ? 4'hf : 4'h0;
      endcase
   endfunction

   function automatic bit pdir(int md, int k);
      int p;
      if (md == 1) return 1'b1;
      if (md != 2) return 1'b0;
      p = k % 6;
      return (p >= 4) || (p == 0 && k > 0);
   endfunction

   task automatic model_reset();
      m_busy = 0; m_held = 0; m_tick = 0;
      m_mode = 0; m_k = 0; m_cnt = 0;
   endtask

   task automatic model_update();
      m_tick = 0;
      if (i_stop) begin
         m_busy = 0; m_held = 0; m_k = 0; m_cnt = 0;
      end else if (i_start) begin
         m_busy = 1; m_held = 0; m_mode = int'(i_mode); m_k = 0; m_cnt = 0;
      end else if (m_busy && !m_held) begin
         if (i_hold) m_held = 1;
         else if (m_cnt >= LIM[i_speed]) begin
            m_cnt = 0; m_k++; m_tick = 1;
         end else m_cnt++;
      end else if (m_held && !i_hold) begin
         m_held = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] e_led;
      logic       e_dir;
      e_led = m_busy ? pat(m_mode, m_k) : 4'h0;
      e_dir = m_busy ? pdir(m_mode, m_k) : 1'b0;
      chk("led",   32'(o_led),   32'(e_led));
      chk("dir",   32'(o_dir),   32'(e_dir));
      chk("tick",  32'(o_tick),  32'(m_tick));
      chk("busy",  32'(o_busy),  32'(m_busy));
      chk("led_b", 32'(o_led_b), 32'(e_dir ? 4'h0 : e_led));
      chk("led_g", 32'(o_led_g), 32'(e_dir ? e_led : 4'h0));
   endtask

   task automatic cyc();
      model_update();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic start(input int md, input int sp);
      i_mode  = 2'(md);
      i_speed = 2'(sp);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
   endtask

   initial begin
      int guard;
      i_reset = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_hold = 1'b0;
      i_mode = 2'd0; i_speed = 2'd0;
      model_reset();
      #12;
      check_all();
      i_reset = 1'b1;
      repeat (2) cyc();

      // rotate left, fastest rate
      start(0, 0);
      repeat (17) cyc();

      // bounce, 12 steps
      start(2, 0);
      repeat (49) cyc();

      // rotate right, speed dropped mid-count
      start(1, 1);
      guard = 0;
      while (m_cnt != 10 && guard < 40) begin cyc(); guard++; end
      chk("spd_reach_cnt10", 32'(m_cnt), 32'd10);
      i_speed = 2'd0;
      cyc();
      chk("spd_dn_tick", 32'(o_tick), 32'd1);
      repeat (10) cyc();

      // flash with a 20-cycle hold straddling a step
      start(3, 0);
      guard = 0;
      while (m_cnt != 2 && guard < 10) begin cyc(); guard++; end
      i_hold = 1'b1;
      repeat (20) cyc();
      chk("hold_frozen", 32'(o_led), 32'hf);
      i_hold = 1'b0;
      repeat (8) cyc();

      // stop and start together, then restart mid-run
      start(0, 0);
      repeat (6) cyc();
      i_stop = 1'b1; i_start = 1'b1;
      cyc();
      i_stop = 1'b0; i_start = 1'b0;
      chk("stop_wins_busy", 32'(o_busy), 32'd0);
      repeat (3) cyc();
      start(0, 0);
      guard = 0;
      while (m_k != 2 && guard < 20) begin cyc(); guard++; end
      chk("rot_at_0100", 32'(o_led), 32'h4);
      start(0, 0);
      chk("reload_0001", 32'(o_led), 32'h1);
      repeat (5) cyc();

      // asynchronous reset between clock edges
      start(2, 0);
      repeat (7) cyc();
      #3;
      i_reset = 1'b0;
      #1;
      model_reset();
      check_all();
      #2;
      i_reset = 1'b1;
      repeat (10) cyc();
      start(2, 0);
      repeat (6) cyc();

      // random traffic
      repeat (600) begin
         i_stop  = ($urandom % 50) == 0;
         i_start = ($urandom % 25) == 0;
         if (($urandom % 15) == 0) i_hold = ~i_hold;
         i_mode  = 2'($urandom);
         i_speed = (($urandom % 8) == 0) ? 2'd1 : 2'd0;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
